// File: rtl/ysyx_24110015_arbiter_if.sv
`default_nettype none
// ==================================================================
// axi_lite_if: AXI-lite read/write channel bundle
// Rev 1.0
// ==================================================================
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24110015_arbiter.sv
`default_nettype none
// ==================================================================
// ysyx_24110015_arbiter: round-robin 2:1 AXI-lite arbiter (IFU/LSU)
// Rev 1.0
// ==================================================================
module ysyx_24110015_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_lite_if.slave  axi_ifu,
    axi_lite_if.slave  axi_lsu,
    axi_lite_if.master axi_out
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_RD = 2'd1,
        GNT_WR = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d, last_q, last_d;
    logic   ar_done_q, ar_done_d, aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic [ADDR_W-1:0]   w_araddr, w_awaddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W/8-1:0] w_wstrb;
    logic w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
    logic w_rd, w_wr, w_ifu_req, w_lsu_req, w_pick, w_pick_ar;
    logic w_out_arvalid, w_out_awvalid, w_out_wvalid, w_out_rready, w_out_bready;
    logic w_arready_g, w_rvalid_g, w_awready_g, w_wready_g, w_bvalid_g;

    // Owner-selected master request fields
    assign w_araddr  = owner_q ? axi_lsu.araddr  : axi_ifu.araddr;
    assign w_arvalid = owner_q ? axi_lsu.arvalid : axi_ifu.arvalid;
    assign w_rready  = owner_q ? axi_lsu.rready  : axi_ifu.rready;
    assign w_awaddr  = owner_q ? axi_lsu.awaddr  : axi_ifu.awaddr;
    assign w_awvalid = owner_q ? axi_lsu.awvalid : axi_ifu.awvalid;
    assign w_wdata   = owner_q ? axi_lsu.wdata   : axi_ifu.wdata;
    assign w_wstrb   = owner_q ? axi_lsu.wstrb   : axi_ifu.wstrb;
    assign w_wvalid  = owner_q ? axi_lsu.wvalid  : axi_ifu.wvalid;
    assign w_bready  = owner_q ? axi_lsu.bready  : axi_ifu.bready;

    assign w_rd = (state_q == GNT_RD);
    assign w_wr = (state_q == GNT_WR);

    assign w_out_arvalid = w_rd & w_arvalid & ~ar_done_q;
    assign w_out_rready  = w_rd & w_rready;
    assign w_out_awvalid = w_wr & w_awvalid & ~aw_done_q;
    assign w_out_wvalid  = w_wr & w_wvalid & ~w_done_q;
    assign w_out_bready  = w_wr & w_bready;

    assign axi_out.araddr  = w_araddr;
    assign axi_out.arvalid = w_out_arvalid;
    assign axi_out.rready  = w_out_rready;
    assign axi_out.awaddr  = w_awaddr;
    assign axi_out.awvalid = w_out_awvalid;
    assign axi_out.wdata   = w_wdata;
    assign axi_out.wstrb   = w_wstrb;
    assign axi_out.wvalid  = w_out_wvalid;
    assign axi_out.bready  = w_out_bready;

    assign w_arready_g = w_rd & axi_out.arready & ~ar_done_q;
    assign w_rvalid_g  = w_rd & axi_out.rvalid;
    assign w_awready_g = w_wr & axi_out.awready & ~aw_done_q;
    assign w_wready_g  = w_wr & axi_out.wready & ~w_done_q;
    assign w_bvalid_g  = w_wr & axi_out.bvalid;

    // Only the owner ever sees ready/valid or response payload
    assign axi_ifu.arready = ~owner_q & w_arready_g;
    assign axi_ifu.rvalid  = ~owner_q & w_rvalid_g;
    assign axi_ifu.rdata   = owner_q ? '0 : axi_out.rdata;
    assign axi_ifu.rresp   = owner_q ? '0 : axi_out.rresp;
    assign axi_ifu.awready = ~owner_q & w_awready_g;
    assign axi_ifu.wready  = ~owner_q & w_wready_g;
    assign axi_ifu.bvalid  = ~owner_q & w_bvalid_g;
    assign axi_ifu.bresp   = owner_q ? '0 : axi_out.bresp;

    assign axi_lsu.arready = owner_q & w_arready_g;
    assign axi_lsu.rvalid  = owner_q & w_rvalid_g;
    assign axi_lsu.rdata   = owner_q ? axi_out.rdata : '0;
    assign axi_lsu.rresp   = owner_q ? axi_out.rresp : '0;
    assign axi_lsu.awready = owner_q & w_awready_g;
    assign axi_lsu.wready  = owner_q & w_wready_g;
    assign axi_lsu.bvalid  = owner_q & w_bvalid_g;
    assign axi_lsu.bresp   = owner_q ? axi_out.bresp : '0;

    assign w_ifu_req = axi_ifu.arvalid | axi_ifu.awvalid;
    assign w_lsu_req = axi_lsu.arvalid | axi_lsu.awvalid;
    // On a tie the master that did not finish last wins
    assign w_pick    = (w_ifu_req & w_lsu_req) ? ~last_q : w_lsu_req;
    assign w_pick_ar = w_pick ? axi_lsu.arvalid : axi_ifu.arvalid;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (w_ifu_req | w_lsu_req) begin
                    owner_d   = w_pick;
                    state_d   = w_pick_ar ? GNT_RD : GNT_WR;
                    ar_done_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            GNT_RD: begin
                if (w_out_arvalid & axi_out.arready) ar_done_d = 1'b1;
                if (axi_out.rvalid & w_out_rready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            GNT_WR: begin
                if (w_out_awvalid & axi_out.awready) aw_done_d = 1'b1;
                if (w_out_wvalid & axi_out.wready)   w_done_d  = 1'b1;
                if (axi_out.bvalid & w_out_bready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110015_arbiter.sv
`default_nettype none
// ==================================================================
// tb_ysyx_24110015_arbiter: scoreboard bench for the IFU/LSU arbiter
// Rev 1.0
// ==================================================================
module tb_ysyx_24110015_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) ifu_if ();
    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) lsu_if ();
    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) out_if ();

    ysyx_24110015_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .axi_ifu(ifu_if), .axi_lsu(lsu_if), .axi_out(out_if)
    );

    // Master-side drive (index 0 = IFU, 1 = LSU)
    logic [31:0] m_araddr [2];
    logic [31:0] m_awaddr [2];
    logic [31:0] m_wdata  [2];
    logic [3:0]  m_wstrb  [2];
    logic [1:0]  m_arvalid = '0, m_awvalid = '0, m_wvalid = '0;
    assign ifu_if.araddr = m_araddr[0];  assign lsu_if.araddr = m_araddr[1];
    assign ifu_if.awaddr = m_awaddr[0];  assign lsu_if.awaddr = m_awaddr[1];
    assign ifu_if.wdata  = m_wdata[0];   assign lsu_if.wdata  = m_wdata[1];
    assign ifu_if.wstrb  = m_wstrb[0];   assign lsu_if.wstrb  = m_wstrb[1];
    assign ifu_if.arvalid = m_arvalid[0]; assign lsu_if.arvalid = m_arvalid[1];
    assign ifu_if.awvalid = m_awvalid[0]; assign lsu_if.awvalid = m_awvalid[1];
    assign ifu_if.wvalid  = m_wvalid[0];  assign lsu_if.wvalid  = m_wvalid[1];
    assign ifu_if.rready = 1'b1; assign lsu_if.rready = 1'b1;
    assign ifu_if.bready = 1'b1; assign lsu_if.bready = 1'b1;

    wire [1:0] s_arready = {lsu_if.arready, ifu_if.arready};
    wire [1:0] s_awready = {lsu_if.awready, ifu_if.awready};
    wire [1:0] s_wready  = {lsu_if.wready,  ifu_if.wready};
    wire [1:0] s_rvalid  = {lsu_if.rvalid,  ifu_if.rvalid};
    wire [1:0] s_bvalid  = {lsu_if.bvalid,  ifu_if.bvalid};
    logic [31:0] s_rdata [2];
    logic [1:0]  s_rresp [2];
    logic [1:0]  s_bresp [2];
    assign s_rdata[0] = ifu_if.rdata; assign s_rdata[1] = lsu_if.rdata;
    assign s_rresp[0] = ifu_if.rresp; assign s_rresp[1] = lsu_if.rresp;
    assign s_bresp[0] = ifu_if.bresp; assign s_bresp[1] = lsu_if.bresp;

    int total = 0, bad = 0;
    int issued [2] = '{0, 0};
    int done   [2] = '{0, 0};
    int order [$];
    logic [33:0] exp_r0 [$], exp_r1 [$];
    logic [1:0]  exp_b0 [$], exp_b1 [$];
    logic [31:0] last_rdata [2];
    logic [1:0]  last_rresp [2], last_bresp [2];

    // Slave knobs and observation counters
    int  rdy_pct = 100, max_dly = 0;
    bit  ar_en = 1, aw_en = 1, w_en = 1, r_en = 1;
    int  ar_seen = 0, w_seen = 0;

    // Reference slave behaviour: read reply and write response derived from the request
    function automatic logic [33:0] rd_model(input logic [31:0] a);
        return {a[3:2], a ^ 32'h8000_0413};
    endfunction
    function automatic logic [1:0] wr_model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        return a[1:0] ^ d[1:0] ^ s[1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] outs_vec();
        return {out_if.arvalid, out_if.awvalid, out_if.wvalid, out_if.rready, out_if.bready,
                s_arready, s_awready, s_wready, s_rvalid, s_bvalid};
    endfunction

    task automatic tick(); @(negedge clk); #1; endtask
    task automatic drv();  @(posedge clk); #2; endtask

    task automatic issue_rd(input int m, input logic [31:0] a);
        m_araddr[m] = a; m_arvalid[m] = 1'b1; issued[m]++;
        if (m == 0) exp_r0.push_back(rd_model(a)); else exp_r1.push_back(rd_model(a));
    endtask
    task automatic issue_wr(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_awaddr[m] = a; m_wdata[m] = d; m_wstrb[m] = s;
        m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1; issued[m]++;
        if (m == 0) exp_b0.push_back(wr_model(a, d, s)); else exp_b1.push_back(wr_model(a, d, s));
    endtask

    task automatic clear_masters();
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        exp_r0.delete(); exp_r1.delete(); exp_b0.delete(); exp_b1.delete();
        issued = '{0, 0}; done = '{0, 0};
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        clear_masters();
        repeat (2) drv();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int m, input int budget);
        while (done[m] < issued[m] && budget > 0) begin tick(); budget--; end
        if (done[m] < issued[m]) begin
            total++; bad++;
            $display("FAIL timeout_m%0d: got %0d completions expected %0d", m, done[m], issued[m]);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake, checks exclusivity
    initial begin
        bit ar_h [2], aw_h [2], w_h [2];
        logic [33:0] e;
        logic [1:0]  eb;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                ar_h[m] = m_arvalid[m] & s_arready[m];
                aw_h[m] = m_awvalid[m] & s_awready[m];
                w_h[m]  = m_wvalid[m]  & s_wready[m];
                if (s_rvalid[m]) begin
                    last_rdata[m] = s_rdata[m]; last_rresp[m] = s_rresp[m];
                    if ((m == 0 ? exp_r0.size() : exp_r1.size()) == 0) begin
                        total++; bad++;
                        $display("FAIL r_unexpected_m%0d: got rvalid expected none", m);
                    end else begin
                        if (m == 0) e = exp_r0.pop_front(); else e = exp_r1.pop_front();
                        chk($sformatf("rdata_m%0d", m), {s_rresp[m], s_rdata[m]}, e);
                    end
                    done[m]++; order.push_back(m);
                end
                if (s_bvalid[m]) begin
                    last_bresp[m] = s_bresp[m];
                    if ((m == 0 ? exp_b0.size() : exp_b1.size()) == 0) begin
                        total++; bad++;
                        $display("FAIL b_unexpected_m%0d: got bvalid expected none", m);
                    end else begin
                        if (m == 0) eb = exp_b0.pop_front(); else eb = exp_b1.pop_front();
                        chk($sformatf("bresp_m%0d", m), s_bresp[m], eb);
                    end
                    done[m]++; order.push_back(m);
                end
            end
            chk("exclusive", (|{s_arready[0], s_awready[0], s_wready[0], s_rvalid[0], s_bvalid[0]}) &
                             (|{s_arready[1], s_awready[1], s_wready[1], s_rvalid[1], s_bvalid[1]}), 0);
            if (s_rvalid[0]) chk("lsu_rdata_zero", {s_rresp[1], s_rdata[1]}, 0);
            if (s_rvalid[1]) chk("ifu_rdata_zero", {s_rresp[0], s_rdata[0]}, 0);
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (ar_h[m]) m_arvalid[m] = 1'b0;
                if (aw_h[m]) m_awvalid[m] = 1'b0;
                if (w_h[m])  m_wvalid[m]  = 1'b0;
            end
        end
    end

    // Downstream slave model
    initial begin
        bit rd_pend, aw_got, w_got, r_hs, b_hs;
        logic [31:0] rd_addr, wa, wd;
        logic [3:0]  ws;
        int rdly, bdly;
        rd_pend = 0; aw_got = 0; w_got = 0; rdly = 0; bdly = 0;
        rd_addr = '0; wa = '0; wd = '0; ws = '0;
        out_if.arready = 0; out_if.awready = 0; out_if.wready = 0;
        out_if.rvalid = 0; out_if.bvalid = 0; out_if.rdata = '0; out_if.rresp = '0; out_if.bresp = '0;
        forever begin
            @(negedge clk);
            r_hs = out_if.rvalid & out_if.rready;
            b_hs = out_if.bvalid & out_if.bready;
            if (out_if.arvalid & out_if.arready) begin
                rd_pend = 1; rd_addr = out_if.araddr; rdly = $urandom_range(0, max_dly); ar_seen++;
            end
            if (out_if.awvalid & out_if.awready) begin aw_got = 1; wa = out_if.awaddr; end
            if (out_if.wvalid & out_if.wready) begin
                w_got = 1; wd = out_if.wdata; ws = out_if.wstrb; w_seen++;
            end
            if (aw_got && w_got) bdly = (bdly > 0) ? bdly : $urandom_range(0, max_dly);
            @(posedge clk); #1;
            if (!rst_n) begin
                rd_pend = 0; aw_got = 0; w_got = 0; bdly = 0;
                out_if.arready = 0; out_if.awready = 0; out_if.wready = 0;
                out_if.rvalid = 0; out_if.bvalid = 0;
                continue;
            end
            if (r_hs) out_if.rvalid = 0;
            if (b_hs) out_if.bvalid = 0;
            if (rd_pend && !out_if.rvalid && r_en) begin
                if (rdly == 0) begin
                    out_if.rvalid = 1; {out_if.rresp, out_if.rdata} = rd_model(rd_addr); rd_pend = 0;
                end else rdly--;
            end
            if (aw_got && w_got && !out_if.bvalid) begin
                if (bdly == 0) begin
                    out_if.bvalid = 1; out_if.bresp = wr_model(wa, wd, ws); aw_got = 0; w_got = 0;
                end else bdly--;
            end
            out_if.arready = ar_en && !rd_pend && !out_if.rvalid && ($urandom_range(0, 99) < rdy_pct);
            out_if.awready = aw_en && !aw_got && !out_if.bvalid && ($urandom_range(0, 99) < rdy_pct);
            out_if.wready  = w_en  && !w_got  && !out_if.bvalid && ($urandom_range(0, 99) < rdy_pct);
        end
    end

    task automatic gen(input int m, input int n);
        int kind;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) drv();
            drv();
            kind = $urandom_range(0, 9);
            if (kind < 4) issue_rd(m, $urandom);
            else if (kind < 8) issue_wr(m, $urandom, $urandom, 4'($urandom_range(0, 15)));
            else begin
                issue_rd(m, $urandom);
                issue_wr(m, $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            wait_idle(m, 400);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int budget, n_iss, a0, w0;
        for (int m = 0; m < 2; m++) begin
            m_araddr[m] = '0; m_awaddr[m] = '0; m_wdata[m] = '0; m_wstrb[m] = '0;
        end
        // Single IFU read, one-cycle arbitration latency
        ar_en = 0;
        drv();
        issue_rd(0, 32'h8000_0000);
        tick();
        chk("reset_outputs", outs_vec(), 0);
        drv();
        rst_n = 1'b1;
        tick();
        chk("t1_idle_arvalid", out_if.arvalid, 0);
        tick();
        chk("t1_arvalid", out_if.arvalid, 1);
        chk("t1_araddr", out_if.araddr, 32'h8000_0000);
        ar_en = 1;
        wait_idle(0, 100);
        chk("t1_rdata", {last_rresp[0], last_rdata[0]}, 34'h0_0000_0413);

        // Tie after reset: IFU first, LSU two cycles after IFU r handshake
        do_reset();
        drv();
        issue_rd(0, 32'h8000_0100); issue_rd(1, 32'h0000_0104);
        tick(); tick();
        chk("t2_arvalid", out_if.arvalid, 1);
        chk("t2_araddr_ifu", out_if.araddr, 32'h8000_0100);
        budget = 100;
        while (done[0] < 1 && budget > 0) begin
            chk("t2_lsu_held", s_arready[1], 0);
            tick(); budget--;
        end
        chk("t2_ifu_done", done[0], 1);
        tick();
        chk("t2_gap_arvalid", out_if.arvalid, 0);
        tick();
        chk("t2_lsu_arvalid", out_if.arvalid, 1);
        chk("t2_araddr_lsu", out_if.araddr, 32'h0000_0104);
        wait_idle(1, 100);

        // Back-to-back ties alternate
        do_reset();
        order.delete();
        drv();
        issue_rd(0, 32'h8000_0200); issue_rd(1, 32'h0000_0204);
        n_iss = 2; budget = 400;
        while (done[0] + done[1] < 4 && budget > 0) begin
            tick(); budget--;
            for (int m = 0; m < 2; m++)
                if (done[m] == issued[m] && n_iss < 4) begin
                    drv(); issue_rd(m, 32'h0000_1000 + 32'(n_iss * 4)); n_iss++;
                end
        end
        chk("t3_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk($sformatf("t3_order%0d", i), order[i], i % 2);

        // LSU write, slave takes w two cycles before aw
        do_reset();
        aw_en = 0;
        drv();
        issue_wr(1, 32'ha000_03f8, 32'h0000_0041, 4'h1);
        w0 = w_seen; budget = 50;
        while (w_seen == w0 && budget > 0) begin tick(); budget--; end
        chk("t4_w_seen", w_seen, w0 + 1);
        tick();
        chk("t4_wvalid_dropped", out_if.wvalid, 0);
        chk("t4_awvalid_held", out_if.awvalid, 1);
        aw_en = 1;
        wait_idle(1, 100);
        chk("t4_bresp", last_bresp[1], 2'b00);
        chk("t4_ifu_untouched", done[0], 0);
        drv();
        issue_rd(0, 32'h8000_0300); issue_rd(1, 32'h0000_0304);
        tick(); tick();
        chk("t4_next_tie_ifu", {out_if.arvalid, out_if.araddr}, {1'b1, 32'h8000_0300});
        wait_idle(0, 100); wait_idle(1, 100);

        // LSU arvalid + awvalid together: read first, aw held
        do_reset();
        drv();
        issue_rd(1, 32'h0000_2008);
        issue_wr(1, 32'h0000_3000, 32'h1234_5678, 4'hf);
        budget = 100;
        while (done[1] < 1 && budget > 0) begin
            chk("t5_awready_held", {s_awready[1], out_if.awvalid}, 0);
            tick(); budget--;
        end
        chk("t5_rresp", last_rresp[1], 2'b10);
        wait_idle(1, 100);

        // Asynchronous reset mid-read after the address handshake
        do_reset();
        r_en = 0;
        drv();
        issue_rd(0, 32'h8000_0010);
        a0 = ar_seen; budget = 50;
        while (ar_seen == a0 && budget > 0) begin tick(); budget--; end
        tick();
        chk("t6_rready_before", {out_if.rready, out_if.arvalid}, 2'b10);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_drop", outs_vec(), 0);
        clear_masters();
        drv(); drv();
        rst_n = 1'b1;
        r_en = 1;
        drv();
        issue_rd(0, 32'h8000_0400); issue_rd(1, 32'h0000_0404);
        tick(); tick();
        chk("t6_tie_ifu", {out_if.arvalid, out_if.araddr}, {1'b1, 32'h8000_0400});
        wait_idle(0, 100); wait_idle(1, 100);

        // Randomized traffic from both masters
        do_reset();
        rdy_pct = 60; max_dly = 3;
        fork
            gen(0, 40);
            gen(1, 40);
        join
        repeat (5) tick();
        chk("rand_queues_empty", exp_r0.size() + exp_r1.size() + exp_b0.size() + exp_b1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ysyx_24110015_arbiter.md
# ysyx_24110015_arbiter

- Two-master to one-slave AXI-lite arbiter; the N:1 counterpart to the address-decoding crossbar.
- Instruction-fetch (IFU) and load/store (LSU) masters share one downstream AXI-lite port, which feeds the crossbar.
- Grants one whole transaction at a time, round-robin, and forwards every channel of the granted master unchanged.
- The non-granted master is held off with all ready/valid signals low.

## Interface
Parameters:
- ADDR_W, 32, address width of all three ports.
- DATA_W, 32, data width; wstrb is DATA_W/8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- axi_ifu  axi_lite_if.slave  bundle  IFU master port (read and write channels).
- axi_lsu  axi_lite_if.slave  bundle  LSU master port (read and write channels).
- axi_out  axi_lite_if.master  bundle  downstream port to the crossbar.

## Operation
State machine states:
- IDLE: no grant.
- GNT_RD: read granted.
- GNT_WR: write granted.

Registers:
- owner: 0 = IFU, 1 = LSU.
- last: owner of the most recent completed grant.
- ar_done, aw_done, w_done.

IDLE:
- Each master requests when arvalid | awvalid.
- Only one requests: grant it.
- Both request: grant the master that is not last (round-robin).
- Within the granted master, arvalid beats awvalid, so a read wins when both are valid; next state is GNT_RD, otherwise GNT_WR.
- owner and the ar_done/aw_done/w_done flags are loaded on the transition; the flags clear.

GNT_RD:
- out.araddr = owner.araddr.
- out.arvalid = owner.arvalid & ~ar_done; owner.arready = out.arready & ~ar_done.
- On out.arvalid & out.arready, set ar_done.
- owner.rvalid/rdata/rresp = out.r*; out.rready = owner.rready.
- On r handshake: last <= owner, then IDLE.

GNT_WR:
- aw and w are forwarded independently with the same gating, using aw_done and w_done.
- Either order is allowed, including simultaneous.
- b channel is forwarded from out to owner.
- On b handshake: last <= owner, then IDLE.

Muxing:
- All address, data, wstrb and resp fields are muxed by owner; there is no broadcast.
- In IDLE, out.* valid/ready are 0 and addr/data follow owner (don't-care).
- Non-owner master: arready, awready, wready, rvalid and bvalid are 0; rdata and rresp are 0.

Passthrough:
- rresp and bresp pass through unmodified; the arbiter never generates errors.
- A response valid arriving before the address handshake is forwarded as-is.

## Timing
Reset:
- rst_n low forces state = IDLE, owner = 0, last = 1, and all flags 0, immediately.
- Because last = 1, the first tie after reset goes to IFU.
- All axi_out valids and all master-side readies/valids are 0 during reset.
- Reset asserted mid-transaction abandons the transaction with no completion.

Latency:
- A request first seen in IDLE in cycle N appears on axi_out in cycle N+1.
- The arbitration cost is one cycle.
- After the response handshake in cycle M, the arbiter is in IDLE in M+1, and the next grant drives axi_out in M+2 at the earliest.

Handshakes and hold rules:
- Masters hold valid until the handshake, per AXI; the arbiter does not latch addresses or data.
- Requests that change in IDLE are re-evaluated every cycle; only the value in the transition cycle counts.
- A request from the non-owner during a grant is held off (ready = 0) until after completion.

Edge cases:
- IFU arvalid and LSU awvalid in the same IDLE cycle: round-robin decides.
- Same-cycle aw and w handshakes set both flags.
- A b handshake before w_done is forwarded and terminates the grant.

## Test plan
1. Reset then IFU arvalid = 1, araddr = 0x8000_0000: out.arvalid = 1 in the next cycle. Slave returns rdata = 0x0000_0413, rresp = 0. IFU receives rdata = 0x0000_0413, and the state returns to IDLE one cycle after the r handshake.
2. IFU and LSU both assert arvalid in the same IDLE cycle after reset: IFU is granted first and LSU.arready stays 0. After IFU completes, LSU is granted with out.arvalid high two cycles after the IFU r handshake.
3. Back-to-back ties, 4 transactions: grants alternate IFU, LSU, IFU, LSU.
4. LSU write with awaddr = 0xa000_03f8, wdata = 0x41, wstrb = 0x1, and the slave accepting w two cycles before aw: out.wvalid drops after the w handshake. bresp = 0 reaches LSU, IFU sees bvalid = 0 throughout, and last = LSU.
5. LSU asserts arvalid and awvalid together: a read is performed and awready stays 0 until the next grant. The slave returns rresp = 2'b10, which LSU receives unchanged.
6. rst_n pulled low during GNT_RD after ar_done: all outputs drop to 0 asynchronously and the state is IDLE after release. The next tie goes to IFU.
